// File: rtl/vga_capture_pkg.sv
// vga_capture_pkg: shared types and constants for the VGA capture block.
package vga_capture_pkg;
  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} cap_state_t;
  typedef logic [9:0] xcoord_t;
  typedef logic [8:0] ycoord_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  localparam logic [7:0] ERR_MAX = 8'd255;
endpackage

// File: rtl/vga_capture_if.sv
// vga_capture_if: VGA pin bundle; master is the transmitter, slave the capture side.
interface vga_capture_if;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  modport master (output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B);
  modport slave  (input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B);
endinterface

// File: rtl/vga_capture_edge.sv
// vga_edge_sync: two-flop register of one VGA pin with rising (FALL=0) or falling (FALL=1) edge detect.
module vga_edge_sync #(
  parameter bit FALL = 1'b0
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic d,
  output logic det
);
  logic s1_q, s2_q;
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  assign det = FALL ? (~s1_q & s2_q) : (s1_q & ~s2_q);
endmodule

// File: rtl/vga_capture.sv
// vga_capture: recovers pixels from sampled VGA pins and checks line/frame geometry.
// Optional VGA_CAPTURE_SIG_EN adds frame_sig, the 24-bit modular colour sum of each frame.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  vga_capture_if.slave vga,
  output logic        px_valid,
  output xcoord_t     px_x,
  output ycoord_t     px_y,
  output logic [7:0]  px_r,
  output logic [7:0]  px_g,
  output logic [7:0]  px_b,
  output logic        frame_done,
  output logic        locked,
  output logic        err_h,
  output logic        err_v,
  output logic [7:0]  err_count
`ifdef VGA_CAPTURE_SIG_EN
  ,
  output logic [23:0] frame_sig
`endif
);
  localparam xcoord_t    XW = xcoord_t'(WIDTH);
  localparam ycoord_t    YH = ycoord_t'(HEIGHT);
  localparam logic [3:0] LF = 4'(LOCK_FRAMES);
  logic pix_en, hs_fall, vs_fall;
  vga_edge_sync #(.FALL(1'b0)) u_clk (.CLOCK_50, .reset_n, .d(vga.VGA_CLK), .det(pix_en));
  vga_edge_sync #(.FALL(1'b1)) u_hs  (.CLOCK_50, .reset_n, .d(vga.VGA_HS),  .det(hs_fall));
  vga_edge_sync #(.FALL(1'b1)) u_vs  (.CLOCK_50, .reset_n, .d(vga.VGA_VS),  .det(vs_fall));
  cap_state_t state_q, state_d;
  logic [3:0] good_q, good_d;
  xcoord_t    x_q, x_d, px_x_q, px_x_d;
  ycoord_t    y_q, y_d, y_eff, px_y_q, px_y_d;
  rgb_t       rgb_s1_q, px_rgb_q, px_rgb_d;
  logic       blank_s1_q, ovr_q, ovr_d, herr_q, herr_d;
  logic       pv_q, pv_d, fd_q, fd_d, lk_q, lk_d, eh_q, eh_d, ev_q, ev_d;
  logic [7:0] ec_q, ec_d;
  logic [8:0] ec_sum;
  logic       hunt, pix, act_line, bad_line, frame_ok;
  // A line closing together with vs_fall is folded into y_eff so the frame check sees it.
  always_comb begin
    hunt     = state_q == HUNT;
    pix      = pix_en & blank_s1_q;
    act_line = hs_fall & (x_q != '0);
    bad_line = act_line & ((x_q != XW) | ovr_q);
    y_eff    = (act_line && y_q != YH) ? y_q + 1'b1 : y_q;
    frame_ok = (y_eff == YH) & ~herr_q & ~bad_line;
    x_d      = hs_fall ? '0 : (pix && x_q != XW) ? x_q + 1'b1 : x_q;
    ovr_d    = ~hs_fall & (ovr_q | (pix & (x_q == XW)));
    y_d      = vs_fall ? '0 : y_eff;
    herr_d   = ~vs_fall & (herr_q | bad_line);
    pv_d     = pix & ~hunt & (x_q < XW) & (y_q < YH);
    px_x_d   = pv_d ? x_q : px_x_q;
    px_y_d   = pv_d ? y_q : px_y_q;
    px_rgb_d = pv_d ? rgb_s1_q : px_rgb_q;
    fd_d     = vs_fall & ~hunt;
    eh_d     = bad_line & ~hunt;
    ev_d     = fd_d & (y_eff != YH);
    ec_sum   = {1'b0, ec_q} + {8'd0, eh_d} + {8'd0, ev_d};
    ec_d     = (ec_sum > {1'b0, ERR_MAX}) ? ERR_MAX : ec_sum[7:0];
    state_d  = state_q;
    good_d   = good_q;
    case (state_q)
      HUNT: if (vs_fall) begin
        state_d = SYNC;
        good_d  = '0;
      end
      SYNC: if (vs_fall) begin
        good_d = frame_ok ? good_q + 1'b1 : '0;
        if (frame_ok && good_q + 1'b1 == LF) state_d = LOCKED;
      end
      default: if (eh_d || (vs_fall && !frame_ok)) begin
        state_d = SYNC;
        good_d  = '0;
      end
    endcase
    lk_d = state_d == LOCKED;
  end
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      state_q    <= HUNT;
      good_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      ovr_q      <= 1'b0;
      herr_q     <= 1'b0;
      rgb_s1_q   <= '0;
      blank_s1_q <= 1'b0;
      pv_q       <= 1'b0;
      px_x_q     <= '0;
      px_y_q     <= '0;
      px_rgb_q   <= '0;
      fd_q       <= 1'b0;
      lk_q       <= 1'b0;
      eh_q       <= 1'b0;
      ev_q       <= 1'b0;
      ec_q       <= '0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      x_q        <= x_d;
      y_q        <= y_d;
      ovr_q      <= ovr_d;
      herr_q     <= herr_d;
      rgb_s1_q   <= {vga.VGA_R, vga.VGA_G, vga.VGA_B};
      blank_s1_q <= vga.VGA_BLANK_N;
      pv_q       <= pv_d;
      px_x_q     <= px_x_d;
      px_y_q     <= px_y_d;
      px_rgb_q   <= px_rgb_d;
      fd_q       <= fd_d;
      lk_q       <= lk_d;
      eh_q       <= eh_d;
      ev_q       <= ev_d;
      ec_q       <= ec_d;
    end
  assign px_valid   = pv_q;
  assign px_x       = px_x_q;
  assign px_y       = px_y_q;
  assign px_r       = px_rgb_q.r;
  assign px_g       = px_rgb_q.g;
  assign px_b       = px_rgb_q.b;
  assign frame_done = fd_q;
  assign locked     = lk_q;
  assign err_h      = eh_q;
  assign err_v      = ev_q;
  assign err_count  = ec_q;
`ifdef VGA_CAPTURE_SIG_EN
  logic [23:0] acc_q, acc_d, sig_q, sig_d, add;
  always_comb begin
    add   = pv_d ? rgb_s1_q : '0;
    acc_d = vs_fall ? '0 : acc_q + add;
    sig_d = vs_fall ? acc_q + add : sig_q;
  end
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      acc_q <= '0;
      sig_q <= '0;
    end else begin
      acc_q <= acc_d;
      sig_q <= sig_d;
    end
  assign frame_sig = sig_q;
`endif
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: drives synthetic VGA frames and checks capture, geometry errors and lock against a frame-level model.
module tb_vga_capture;
  import vga_capture_pkg::*;
  localparam int W = 8, H = 4, LOCKN = 2;
  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       px_valid, frame_done, locked, err_h, err_v;
  xcoord_t    px_x;
  ycoord_t    px_y;
  logic [7:0] px_r, px_g, px_b, err_count;
`ifdef VGA_CAPTURE_SIG_EN
  logic [23:0] frame_sig;
`endif
  vga_capture_if vga ();
  vga_capture #(.WIDTH(W), .HEIGHT(H), .LOCK_FRAMES(LOCKN)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .vga(vga),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
    .px_r(px_r), .px_g(px_g), .px_b(px_b),
    .frame_done(frame_done), .locked(locked), .err_h(err_h), .err_v(err_v),
    .err_count(err_count)
`ifdef VGA_CAPTURE_SIG_EN
    , .frame_sig(frame_sig)
`endif
  );
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [31:0] stamp;
  } px_t;
  px_t         q[$];
  int          cyc, checks, passes;
  int          n_px, n_fd, n_eh, n_ev;
  int          px_exp, fd_exp, eh_exp, ev_exp, ec_exp, run;
  bit          seen_vs;
  logic [23:0] sig_acc;

  always @(posedge CLOCK_50) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLOCK_50) if (reset_n) begin
    if (frame_done) n_fd++;
    if (err_v) n_ev++;
    if (err_h) begin
      n_eh++;
      chk("locked_at_err_h", {31'd0, locked}, 32'd0);
    end
    if (px_valid) begin
      px_t e;
      n_px++;
      chk("px_expected", {31'd0, q.size() > 0}, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("px_x", 32'(px_x), e.x);
        chk("px_y", 32'(px_y), e.y);
        chk("px_r", 32'(px_r), 32'(e.r));
        chk("px_g", 32'(px_g), 32'(e.g));
        chk("px_b", 32'(px_b), 32'(e.b));
        chk("px_latency", 32'(cyc) - e.stamp, 32'd2);
      end
    end
  end

  task automatic drive(input bit c, input bit hs, input bit vs, input bit bl,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(posedge CLOCK_50);
    #1;
    vga.VGA_CLK = c; vga.VGA_HS = hs; vga.VGA_VS = vs; vga.VGA_BLANK_N = bl;
    vga.VGA_R = r; vga.VGA_G = g; vga.VGA_B = b;
  endtask

  // One line: 2 pixels HS low, 1 back porch, n active, 1 front porch; mode 0 pattern, 1 random, 2 constant 0x010203.
  task automatic send_line(input int n, input int y, input bit vs, input int mode);
    for (int i = 0; i < n + 4; i++) begin
      bit act;
      int x;
      logic [7:0] r, g, b;
      act = i >= 3 && i < n + 3;
      x = i - 3;
      r = !act ? 8'h00 : mode == 1 ? 8'($urandom) : mode == 2 ? 8'h01 : 8'(x);
      g = !act ? 8'h00 : mode == 1 ? 8'($urandom) : mode == 2 ? 8'h02 : 8'(y);
      b = !act ? 8'h00 : mode == 1 ? 8'($urandom) : mode == 2 ? 8'h03 : 8'(x ^ y);
      drive(1'b1, i >= 2, !vs, act, r, g, b);
      if (act && seen_vs && x < W && y < H) begin
        q.push_back({32'(x), 32'(y), r, g, b, 32'(cyc)});
        px_exp++;
        sig_acc += {r, g, b};
      end
      drive(1'b0, i >= 2, !vs, act, r, g, b);
    end
  endtask

  // nl active lines of W pixels except line bi which has bn pixels, then two blank lines, VS low in the second.
  task automatic send_frame(input int nl, input int bi, input int bn, input int mode);
    bit hunt, good;
    int act, badl, yeff, ev;
    hunt = !seen_vs;
    act = 0;
    badl = 0;
    for (int i = 0; i < nl; i++) begin
      int n;
      n = (i == bi) ? bn : W;
      send_line(n, act, 1'b0, mode);
      if (n > 0) begin
        act++;
        if (n != W) badl++;
      end
    end
    send_line(0, 0, 1'b0, mode);
    send_line(0, 0, 1'b1, mode);
    if (!hunt) begin
      yeff = act < H ? act : H;
      ev = (yeff != H) ? 1 : 0;
      good = yeff == H && badl == 0;
      fd_exp++;
      eh_exp += badl;
      ev_exp += ev;
      ec_exp = (ec_exp + badl + ev > 255) ? 255 : ec_exp + badl + ev;
      run = good ? run + 1 : 0;
    end
    seen_vs = 1'b1;
    chk("px_pending", 32'(q.size()), 32'd0);
    chk("px_count", 32'(n_px), 32'(px_exp));
    chk("frame_done_count", 32'(n_fd), 32'(fd_exp));
    chk("err_h_count", 32'(n_eh), 32'(eh_exp));
    chk("err_v_count", 32'(n_ev), 32'(ev_exp));
    chk("err_count", 32'(err_count), 32'(ec_exp));
    chk("locked", {31'd0, locked}, {31'd0, run >= LOCKN});
`ifdef VGA_CAPTURE_SIG_EN
    chk("frame_sig", 32'(frame_sig), 32'(sig_acc));
`endif
    sig_acc = '0;
  endtask

  task automatic check_zero(input string p);
    chk({p, "_px_valid"}, {31'd0, px_valid}, 32'd0);
    chk({p, "_px_x"}, 32'(px_x), 32'd0);
    chk({p, "_px_y"}, 32'(px_y), 32'd0);
    chk({p, "_px_rgb"}, 32'({px_r, px_g, px_b}), 32'd0);
    chk({p, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({p, "_locked"}, {31'd0, locked}, 32'd0);
    chk({p, "_err_h"}, {31'd0, err_h}, 32'd0);
    chk({p, "_err_v"}, {31'd0, err_v}, 32'd0);
    chk({p, "_err_count"}, 32'(err_count), 32'd0);
`ifdef VGA_CAPTURE_SIG_EN
    chk({p, "_frame_sig"}, 32'(frame_sig), 32'd0);
`endif
  endtask

  initial begin
    sig_acc = '0;
    vga.VGA_CLK = 1'b0; vga.VGA_HS = 1'b1; vga.VGA_VS = 1'b1; vga.VGA_BLANK_N = 1'b0;
    vga.VGA_R = '0; vga.VGA_G = '0; vga.VGA_B = '0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_zero("reset");
    reset_n = 1'b1;
    repeat (3) send_frame(4, 9, W, 0);
    send_frame(4, 1, W + 1, 0);
    repeat (2) send_frame(4, 9, W, 0);
    send_frame(3, 9, W, 0);
    send_frame(4, 9, W, 2);
    for (int f = 0; f < 6; f++)
      send_frame($urandom_range(3, 5), $urandom_range(0, 6), $urandom_range(W - 1, W + 1), 1);
    repeat (3) send_frame(4, 9, W, 1);
    chk("locked_before_reset", {31'd0, locked}, {31'd0, run >= LOCKN});
    fork
      send_line(W, 0, 1'b0, 0);
      begin
        repeat (10) @(posedge CLOCK_50);
        #3;
        reset_n = 1'b0;
        px_exp -= q.size();
        q.delete();
        seen_vs = 1'b0;
        run = 0;
        ec_exp = 0;
        sig_acc = '0;
        #1;
        check_zero("midline_reset");
        repeat (2) @(posedge CLOCK_50);
        #3;
        reset_n = 1'b1;
      end
    join
    send_frame(3, 9, W, 0);
    repeat (2) send_frame(4, 9, W, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
